// File: rtl/esc_reg_pkg.sv
// Shared constants, FSM state type and index helpers for the ESC register bank.
package esc_reg_pkg;

    localparam logic [7:0]  REG_BASE     = 8'h40;
    localparam int unsigned REG_NUM      = 20;
    localparam logic [7:0]  REG_RO_START = 8'h50;
    localparam logic [7:0]  COMMIT_KEY   = 8'hA5;
    localparam logic [7:0]  COMMIT_IDX   = REG_RO_START - 8'h01;
    localparam int unsigned OFF_W        = $clog2(REG_NUM);
    localparam int unsigned CFG_NUM      = 32'(REG_RO_START - REG_BASE);
    localparam int unsigned CFG_W        = $clog2(CFG_NUM);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_I2C  = 2'd1,
        WR_CORE = 2'd2
    } arb_state_t;

    // Offset arithmetic wraps in 8 bits, so indices below the base land far out of range.
    function automatic logic in_bank(input logic [7:0] idx);
        logic [7:0] off;
        off = idx - REG_BASE;
        return (idx >= REG_BASE) && (off < 8'(REG_NUM));
    endfunction

    function automatic logic [OFF_W-1:0] bank_off(input logic [7:0] idx);
        return OFF_W'(idx - REG_BASE);
    endfunction

endpackage

// File: rtl/esc_reg_bank.sv
// 20x8 ESC register storage: one write port, registered I2C and core read ports.
// With SHADOW_COMMIT_EN, config entries get an I2C staging copy committed by a key write.
module esc_reg_bank
    import esc_reg_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       we,
`ifdef SHADOW_COMMIT_EN
    input  logic       wr_i2c,
`endif
    input  logic [7:0] waddr,
    input  logic [7:0] wdata,
    input  logic [7:0] i2c_raddr,
    output logic [7:0] i2c_rdata,
    input  logic [7:0] core_raddr,
    output logic [7:0] core_rdata
);

    logic [7:0]       act_q [REG_NUM];
    logic [OFF_W-1:0] woff_c, i2c_off_c, core_off_c;
    logic [7:0]       i2c_val_c, core_val_c;

    assign woff_c     = bank_off(waddr);
    assign i2c_off_c  = bank_off(i2c_raddr);
    assign core_off_c = bank_off(core_raddr);

`ifdef SHADOW_COMMIT_EN
    logic [7:0] stg_q [CFG_NUM];
    logic       w_cfg_c, w_commit_c;

    assign w_cfg_c    = woff_c < OFF_W'(CFG_NUM);
    assign w_commit_c = wr_i2c && (waddr == COMMIT_IDX) && (wdata == COMMIT_KEY);

    // I2C writes stage config values; the key write publishes them and is not stored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < REG_NUM; i++) act_q[OFF_W'(i)] <= '0;
            for (int unsigned i = 0; i < CFG_NUM; i++) stg_q[CFG_W'(i)] <= '0;
        end else if (we) begin
            if (w_commit_c) begin
                for (int unsigned i = 0; i < CFG_NUM; i++) act_q[OFF_W'(i)] <= stg_q[CFG_W'(i)];
            end else if (wr_i2c && w_cfg_c) begin
                stg_q[woff_c[CFG_W-1:0]] <= wdata;
            end else begin
                act_q[woff_c] <= wdata;
                if (w_cfg_c) stg_q[woff_c[CFG_W-1:0]] <= wdata;
            end
        end
    end
`else
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < REG_NUM; i++) act_q[OFF_W'(i)] <= '0;
        end else if (we) begin
            act_q[woff_c] <= wdata;
        end
    end
`endif

    always_comb begin
        i2c_val_c  = '0;
        core_val_c = '0;
        if (in_bank(i2c_raddr)) i2c_val_c = act_q[i2c_off_c];
`ifdef SHADOW_COMMIT_EN
        if (in_bank(i2c_raddr) && (i2c_off_c < OFF_W'(CFG_NUM)))
            i2c_val_c = stg_q[i2c_off_c[CFG_W-1:0]];
`endif
        if (in_bank(core_raddr)) core_val_c = act_q[core_off_c];
    end

    // Reads see the pre-commit value in the write cycle; no bypass.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i2c_rdata  <= '0;
            core_rdata <= '0;
        end else begin
            i2c_rdata  <= i2c_val_c;
            core_rdata <= core_val_c;
        end
    end

endmodule

// File: rtl/esc_reg_arbiter.sv
// Arbitrates the ESC register bank write port between the I2C slave and the motor core.
// Define SHADOW_COMMIT_EN for staged config registers with a keyed commit.
module esc_reg_arbiter
    import esc_reg_pkg::*;
#(
    parameter int unsigned CORE_MAX_WAIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i2c_write,
    input  logic [7:0] i2c_index,
    input  logic [7:0] i2c_wdata,
    output logic [7:0] i2c_rdata,
    input  logic       core_req,
    input  logic [7:0] core_waddr,
    input  logic [7:0] core_wdata,
    output logic       core_gnt,
    input  logic [7:0] core_raddr,
    output logic [7:0] core_rdata,
    output logic       cfg_upd,
    output logic [7:0] cfg_upd_idx,
    output logic       ovf_err,
    output logic       oor_err,
    input  logic       err_clr
);

    localparam int unsigned WAIT_W = $clog2(CORE_MAX_WAIT + 1);

    arb_state_t        state_q, state_d;
    logic              i2c_wr_d, i2c_pend;
    logic [7:0]        lat_idx, lat_data;
    logic [WAIT_W-1:0] wait_cnt;
    logic              i2c_edge_c, i2c_ok_c, core_ok_c, wr_i2c_c, wr_core_c, bank_we_c;
    logic              ovf_set_c, oor_set_c;
    logic [7:0]        bank_waddr_c, bank_wdata_c;

    assign i2c_edge_c   = i2c_write & ~i2c_wr_d;
    assign i2c_ok_c     = in_bank(lat_idx) && (lat_idx < REG_RO_START);
    assign core_ok_c    = in_bank(core_waddr);
    assign wr_i2c_c     = (state_q == WR_I2C);
    assign wr_core_c    = (state_q == WR_CORE);
    assign bank_we_c    = (wr_i2c_c && i2c_ok_c) || (wr_core_c && core_ok_c);
    assign bank_waddr_c = wr_i2c_c ? lat_idx : core_waddr;
    assign bank_wdata_c = wr_i2c_c ? lat_data : core_wdata;
    // An edge landing while the latch is being committed is a fresh request, not an overrun.
    assign ovf_set_c    = i2c_edge_c && i2c_pend && !wr_i2c_c;
    assign oor_set_c    = (wr_i2c_c && !i2c_ok_c) || (wr_core_c && !core_ok_c);

    always_comb begin
        state_d = IDLE;
        if (state_q == IDLE) begin
            if (i2c_pend && core_req)
                state_d = (wait_cnt >= WAIT_W'(CORE_MAX_WAIT)) ? WR_CORE : WR_I2C;
            else if (i2c_pend)
                state_d = WR_I2C;
            else if (core_req)
                state_d = WR_CORE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            i2c_wr_d    <= 1'b0;
            i2c_pend    <= 1'b0;
            lat_idx     <= '0;
            lat_data    <= '0;
            wait_cnt    <= '0;
            core_gnt    <= 1'b0;
            cfg_upd     <= 1'b0;
            cfg_upd_idx <= '0;
            ovf_err     <= 1'b0;
            oor_err     <= 1'b0;
        end else begin
            state_q  <= state_d;
            i2c_wr_d <= i2c_write;
            core_gnt <= (state_d == WR_CORE);

            if (i2c_edge_c) begin
                lat_idx  <= i2c_index;
                lat_data <= i2c_wdata;
                i2c_pend <= 1'b1;
            end else if (wr_i2c_c) begin
                i2c_pend <= 1'b0;
            end

            if (wr_core_c)
                wait_cnt <= '0;
            else if (core_req && (wait_cnt < WAIT_W'(CORE_MAX_WAIT)))
                wait_cnt <= wait_cnt + WAIT_W'(1);

            cfg_upd <= wr_i2c_c && i2c_ok_c;
            if (wr_i2c_c && i2c_ok_c) cfg_upd_idx <= lat_idx;

            if (ovf_set_c)    ovf_err <= 1'b1;
            else if (err_clr) ovf_err <= 1'b0;
            if (oor_set_c)    oor_err <= 1'b1;
            else if (err_clr) oor_err <= 1'b0;
        end
    end

    esc_reg_bank u_bank (
        .clk        (clk),
        .rst        (rst),
        .we         (bank_we_c),
`ifdef SHADOW_COMMIT_EN
        .wr_i2c     (wr_i2c_c),
`endif
        .waddr      (bank_waddr_c),
        .wdata      (bank_wdata_c),
        .i2c_raddr  (i2c_index),
        .i2c_rdata  (i2c_rdata),
        .core_raddr (core_raddr),
        .core_rdata (core_rdata)
    );

endmodule

// File: doc/esc_reg_arbiter.md
Name: esc_reg_arbiter

Overview:
- Owns the ESC register bank at I2C index 0x40..0x53 (20 x 8-bit).
- Arbitrates its single write port between the I2C slave (edge-detected write pulses) and the motor-control core (req/gnt handshake).
- Serves independent registered read ports to both sides and notifies the core when the I2C side changes a configuration register.
- Sits between the I2C slave's RAM-control signals and the commutation/PWM core.

Parameters:
BASE_ADDR, 8'h40, index of bank entry 0
NUM_REGS, 20, number of bank entries (indices BASE_ADDR..BASE_ADDR+NUM_REGS-1)
RO_START, 8'h50, first status index; I2C writes at or above it are refused
CORE_MAX_WAIT, 4, core wait cycles after which core beats a pending I2C write

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
i2c_write  in  1  I2C write strobe, level; rising edge = one write event
i2c_index  in  8  I2C register index (read and write)
i2c_wdata  in  8  I2C write data, sampled on i2c_write rising edge
i2c_rdata  out  8  bank[i2c_index], registered
core_req  in  1  core write request, held until core_gnt
core_waddr  in  8  core write index
core_wdata  in  8  core write data
core_gnt  out  1  one-cycle grant; write committed at end of this cycle
core_raddr  in  8  core read index
core_rdata  out  8  bank[core_raddr], registered
cfg_upd  out  1  one-cycle pulse: I2C write committed to a config register
cfg_upd_idx  out  8  index of that write, held until next cfg_upd
ovf_err  out  1  sticky: I2C edge arrived while previous I2C write still pending
oor_err  out  1  sticky: write to index outside the bank, or I2C write at/above RO_START
err_clr  in  1  synchronous clear of ovf_err and oor_err

Behaviour:
- Reset (rst=0, immediate): all bank entries 0x00, all outputs 0, FSM IDLE, pending flag and wait counter cleared. An in-flight write is not committed.
- I2C edge detect: i2c_wr_d registered. Edge = i2c_write & ~i2c_wr_d.
  - On edge, latch {i2c_index, i2c_wdata} and set i2c_pend.
  - Edge while i2c_pend=1: new data overwrites the latch and ovf_err is set.
- FSM states IDLE, WR_I2C, WR_CORE. Each WR state lasts exactly one cycle, then returns to IDLE. Peak throughput is one write per 2 cycles.
- IDLE arbitration, evaluated each cycle with registered requests (i2c_pend, core_req):
  - Only one source requesting: that source goes to its WR state.
  - Both requesting: WR_CORE if wait_cnt >= CORE_MAX_WAIT, else WR_I2C.
- wait_cnt increments each cycle core_req=1 and the FSM is not in WR_CORE. It saturates at CORE_MAX_WAIT and clears in WR_CORE.
- WR_I2C:
  - Commits the latch at the ending edge and clears i2c_pend.
  - An edge arriving in the same cycle re-sets i2c_pend with the new data and does not flag ovf_err.
  - Index out of range or >= RO_START: no write, oor_err set, no cfg_upd.
  - Otherwise: cfg_upd=1 for the following cycle and cfg_upd_idx = index.
- WR_CORE:
  - core_gnt=1 during this cycle; core_waddr/core_wdata are committed at the ending edge.
  - Out-of-range index: dropped and oor_err set, but core_gnt is still asserted.
  - The core may write any in-range index, including config registers; no cfg_upd is generated.
- Read ports: 1-cycle latency. An out-of-range index returns 0x00. A read of the index being committed returns the old value that cycle and the new value the next cycle (no bypass).
- err_clr and a same-cycle error event: the set wins.
- Width rules: bank offset = index - BASE_ADDR in 8-bit unsigned arithmetic. In range means index >= BASE_ADDR and offset < NUM_REGS.

Optional Feature:
SHADOW_COMMIT_EN
- Defined:
  - Config registers (BASE_ADDR..RO_START-1) have an I2C-side staging copy and a core-visible active copy.
  - I2C writes update staging only; i2c_rdata reads staging.
  - An I2C write of 0xA5 to index RO_START-1 copies all staging to active in one edge. It is not stored, and produces a single cfg_upd with cfg_upd_idx = RO_START-1.
  - Core writes to config indices update both copies.
- Undefined: a single copy, behaviour as above.

Decomposition:
- Package esc_reg_pkg holds:
  - constants REG_BASE, REG_NUM, REG_RO_START, COMMIT_KEY (8'hA5);
  - FSM state enum arb_state_t;
  - function in_bank(idx).
- One sub-module, esc_reg_bank: 20x8 storage with one write port, two registered read ports, and the optional shadow/commit logic. The arbiter FSM, edge detection, counters and error flags stay in esc_reg_arbiter.

Test Plan:
- I2C pulse idx 0x42 data 0x3C, core idle -> WR_I2C taken. i2c_rdata at 0x42 reads 0x3C two cycles after commit; one cfg_upd pulse with cfg_upd_idx=0x42.
- core_req idx 0x50 data 0x77 held continuously, I2C edge every 2 cycles -> I2C wins until wait_cnt=4, then core_gnt for one cycle; 0x50 reads 0x77.
- I2C edge at idx 0x51 -> no write, oor_err=1, no cfg_upd. err_clr -> oor_err=0.
- Two I2C edges 1 cycle apart while core holds the port (wait_cnt saturated) -> ovf_err=1; second data committed.
- rst low during WR_CORE -> no commit, core_gnt=0, bank 0x00 after release.
- SHADOW_COMMIT_EN: I2C writes 0x44=0x10 -> core_rdata at 0x44 stays 0x00. I2C writes 0x4F=0xA5 -> core_rdata at 0x44=0x10 and 0x4F reads 0x00.
